// File: rtl/neopix_serializer_if.sv
// neopix_serializer_if: bundles the serializer's start/status, frame-RAM read port and serial line.
// Latency: none (plain wires).
// Backpressure: none; the RAM port has a fixed 2-clock read latency and start is a pulse.
// Ports: start (to DUT), rdaddress (from DUT), q (to DUT), dout/busy/done (from DUT).
// slave = serializer side, master = command logic / RAM / line side.
interface neopix_serializer_if;
   logic        start;
   logic [8:0]  rdaddress;
   logic [31:0] q;
   logic        dout;
   logic        busy;
   logic        done;

   modport slave  (input start, input q, output rdaddress, output dout, output busy, output done);
   modport master (output start, output q, input rdaddress, input dout, input busy, input done);
endinterface

// File: rtl/neopix_serializer.sv
// neopix_serializer: streams NUM_LEDS frame-RAM pixel words out as a WS2812-style NRZ waveform.
// Latency: dout rises 3 clocks after start is sampled; NUM_LEDS*NBITS*BIT_CYC + LATCH_CYC clocks later done pulses.
// Backpressure: none; start is ignored while busy, q is consumed at a fixed 2-clock RAM latency.
// Ports: clock, reset (synchronous, active-high); bus (slave): start, q in; rdaddress, dout, busy, done out.
// Build option NEOPIX_RGBW_EN: 32 bits per pixel from q[31:0]; default is 24-bit GRB from q[23:0].
module neopix_serializer #(
   parameter int NUM_LEDS  = 8,
   parameter int T0H_CYC   = 20,
   parameter int T1H_CYC   = 40,
   parameter int BIT_CYC   = 63,
   parameter int LATCH_CYC = 2500
) (
   input  logic               clock,
   input  logic               reset,
   neopix_serializer_if.slave bus
);
`ifdef NEOPIX_RGBW_EN
   localparam int NBITS = 32;
`else
   localparam int NBITS = 24;
`endif
   localparam int CW = $clog2(BIT_CYC);
   localparam int LW = $clog2(LATCH_CYC + 1);
   localparam logic [CW-1:0] T0H        = CW'(T0H_CYC);
   localparam logic [CW-1:0] T1H        = CW'(T1H_CYC);
   localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYC - 1);
   localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 1);
   localparam logic [8:0]    LAST_IDX   = 9'(NUM_LEDS - 1);
   localparam logic [4:0]    BIT_LAST   = 5'(NBITS - 1);

   typedef enum logic [2:0] {IDLE, PRIME, SHIFT, LATCH, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cyc;      // clock within the current bit period (also PRIME wait count)
   logic [LW-1:0]    lcnt;
   logic [8:0]       pix;
   logic [4:0]       bitn;
   logic [NBITS-1:0] shreg;
   logic [NBITS-1:0] hold;     // next pixel, prefetched while the current one shifts
   logic [1:0]       cap;      // counts down to the clock where the prefetched q is valid
   logic [CW-1:0]    cyc_nxt;
   logic [CW-1:0]    hi_cyc;

   assign cyc_nxt = cyc + 1'b1;
   assign hi_cyc  = shreg[NBITS-1] ? T1H : T0H;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         cyc           <= '0;
         lcnt          <= '0;
         pix           <= '0;
         bitn          <= '0;
         shreg         <= '0;
         hold          <= '0;
         cap           <= '0;
         bus.rdaddress <= '0;
         bus.dout      <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         // Address reg + output reg in the RAM: q reflects a new address on the third edge.
         if (cap != 2'd0) begin
            cap <= cap - 2'd1;
            if (cap == 2'd1) hold <= bus.q[NBITS-1:0];
         end

         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.rdaddress <= '0;
                  bus.busy      <= 1'b1;
                  cyc           <= '0;
                  state         <= PRIME;
               end
            end

            PRIME: begin
               if (cyc == CW'(2)) begin
                  shreg    <= bus.q[NBITS-1:0];
                  bus.dout <= 1'b1;
                  cyc      <= '0;
                  pix      <= '0;
                  bitn     <= '0;
                  state    <= SHIFT;
                  if (NUM_LEDS > 1) begin
                     bus.rdaddress <= 9'd1;
                     cap           <= 2'd3;
                  end
               end else begin
                  cyc <= cyc_nxt;
               end
            end

            SHIFT: begin
               if (cyc == CYC_LAST) begin
                  cyc <= '0;
                  if (bitn == BIT_LAST) begin
                     bitn <= '0;
                     if (pix == LAST_IDX) begin
                        bus.dout <= 1'b0;
                        lcnt     <= '0;
                        state    <= LATCH;
                     end else begin
                        pix      <= pix + 9'd1;
                        shreg    <= hold;
                        bus.dout <= 1'b1;
                        // The last pixel is already in hold once rdaddress reaches LAST_IDX.
                        if (bus.rdaddress != LAST_IDX) begin
                           bus.rdaddress <= bus.rdaddress + 9'd1;
                           cap           <= 2'd3;
                        end
                     end
                  end else begin
                     bitn     <= bitn + 5'd1;
                     shreg    <= {shreg[NBITS-2:0], 1'b0};
                     bus.dout <= 1'b1;
                  end
               end else begin
                  cyc      <= cyc_nxt;
                  bus.dout <= (cyc_nxt < hi_cyc);
               end
            end

            LATCH: begin
               if (lcnt == LATCH_LAST) begin
                  bus.done <= 1'b1;
                  state    <= DONE;
               end else begin
                  lcnt <= lcnt + 1'b1;
               end
            end

            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule
